mix_in_unit: RTL and testbench

//  MIX IN-instruction device: receives ASCII over a serial RX line, converts each byte to a
//  6-bit MIX char code, packs 5 codes per 30-bit word and writes one block to memory.

---
 rtl/mix_io_pkg.sv | 67 ++++++
 rtl/uart_rx.sv | 104 ++++++++++
 rtl/mix_in_unit.sv | 224 ++++++++++++++++++++++
 tb/tb_mix_in_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mix_io_pkg.sv
// Shared constants, FSM state encodings and the ASCII -> MIX character code map for the IN unit.
// Optional build macro MIX_IN_LOWERCASE_EN folds ASCII a-z onto the A-Z codes.
package mix_io_pkg;

  localparam int MIX_CARD_UNIT  = 16;
  localparam int MIX_TERM_UNIT  = 19;
  localparam int MIX_CARD_WORDS = 16;
  localparam int MIX_TERM_WORDS = 14;

  localparam logic [5:0] MIX_SPACE = 6'd0;
  localparam logic [7:0] ASCII_LF  = 8'd10;
  localparam logic [7:0] ASCII_CR  = 8'd13;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_PAD   = 3'd2,
    S_SKIP  = 3'd3,
    S_FLUSH = 3'd4
  } in_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // Inverse of the character output table; anything without a MIX glyph becomes a space.
  function automatic logic [5:0] ascii_to_mix(input logic [7:0] ch);
    logic [7:0] c;
    logic [5:0] code;
    c = ch;
`ifdef MIX_IN_LOWERCASE_EN
    if (ch >= 8'd97 && ch <= 8'd122) c = ch - 8'd32;
    else c = ch;
`endif
    code = MIX_SPACE;
    if (c >= 8'd65 && c <= 8'd73)      code = 6'(c - 8'd64);
    else if (c >= 8'd74 && c <= 8'd82) code = 6'(c - 8'd63);
    else if (c >= 8'd83 && c <= 8'd90) code = 6'(c - 8'd61);
    else if (c >= 8'd48 && c <= 8'd57) code = 6'(c - 8'd18);
    else begin
      case (c)
        8'd46:   code = 6'd40;
        8'd44:   code = 6'd41;
        8'd40:   code = 6'd42;
        8'd41:   code = 6'd43;
        8'd43:   code = 6'd44;
        8'd45:   code = 6'd45;
        8'd42:   code = 6'd46;
        8'd47:   code = 6'd47;
        8'd61:   code = 6'd48;
        8'd36:   code = 6'd49;
        8'd60:   code = 6'd50;
        8'd62:   code = 6'd51;
        8'd64:   code = 6'd52;
        8'd59:   code = 6'd53;
        8'd58:   code = 6'd54;
        8'd39:   code = 6'd55;
        default: code = MIX_SPACE;
      endcase
    end
    return code;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling, one-cycle valid strobe.
// A low stop bit is treated as a framing error and the byte is dropped.
module uart_rx
  import mix_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic            r_sync1, r_sync2;
  rx_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]      r_bit, w_bit_nxt;
  logic [7:0]      r_shift, w_shift_nxt;
  logic [7:0]      r_data, w_data_nxt;
  logic            r_valid, w_valid_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    case (r_state)
      RX_IDLE: begin
        w_cnt_nxt = '0;
        if (!r_sync2) w_state_nxt = RX_START;
        else          w_state_nxt = RX_IDLE;
      end
      RX_START: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt_nxt = '0;
          w_bit_nxt = 3'd0;
          // a start bit that has gone high again by mid-bit was a glitch
          if (!r_sync2) w_state_nxt = RX_DATA;
          else          w_state_nxt = RX_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (r_cnt == FULL_LAST) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {r_sync2, r_shift[7:1]};
          if (r_bit == 3'd7) w_state_nxt = RX_STOP;
          else               w_bit_nxt   = r_bit + 3'd1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (r_cnt == FULL_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = RX_IDLE;
          if (r_sync2) begin
            w_data_nxt  = r_shift;
            w_valid_nxt = 1'b1;
          end else begin
            w_valid_nxt = 1'b0;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      r_data  <= 8'd0;
      r_valid <= 1'b0;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/mix_in_unit.sv
// MIX IN device: serial ASCII in, 5 six-bit codes per 30-bit word, one block written per IN.
// Optional build macro MIX_IN_LOWERCASE_EN (see mix_io_pkg::ascii_to_mix).
module mix_in_unit
  import mix_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int CARD_UNIT    = MIX_CARD_UNIT,
  parameter int TERM_UNIT    = MIX_TERM_UNIT,
  parameter int CARD_WORDS   = MIX_CARD_WORDS,
  parameter int TERM_WORDS   = MIX_TERM_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic        start,
  input  logic [5:0]  field,
  input  logic [11:0] addressin,
  output logic [11:0] addressout,
  output logic [29:0] out,
  output logic        store,
  input  logic        ack,
  output logic        stop,
  output logic        busy,
  output logic        overrun
);

  logic [7:0] w_byte;
  logic       w_byte_valid;
  logic [5:0] w_mapped;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk     (clk),
    .reset   (reset),
    .i_rx    (rx),
    .o_data  (w_byte),
    .o_valid (w_byte_valid)
  );

  assign w_mapped = ascii_to_mix(w_byte);

  in_state_t   r_state, w_state_nxt;
  logic        r_is_term, w_is_term_nxt;
  logic [4:0]  r_wc, w_wc_nxt;
  logic [2:0]  r_cc, w_cc_nxt;
  logic [23:0] r_acc, w_acc_nxt;
  logic [29:0] r_out, w_out_nxt;
  logic        r_store, w_store_nxt;
  logic [11:0] r_addr, w_addr_nxt;
  logic        r_stop, w_stop_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_overrun, w_overrun_nxt;
  logic        r_pending, w_pending_nxt;
  logic [11:0] r_next_addr, w_next_addr_nxt;

  logic        w_push;
  logic [5:0]  w_code;
  logic [4:0]  w_nwords;
  logic        w_last_char;
  logic        w_word_done;

  assign w_nwords    = r_is_term ? 5'(TERM_WORDS) : 5'(CARD_WORDS);
  assign w_last_char = (r_cc == 3'd4) && ((r_wc + 5'd1) == w_nwords);

  always_comb begin
    w_state_nxt     = r_state;
    w_is_term_nxt   = r_is_term;
    w_wc_nxt        = r_wc;
    w_cc_nxt        = r_cc;
    w_acc_nxt       = r_acc;
    w_out_nxt       = r_out;
    w_store_nxt     = r_store;
    w_addr_nxt      = r_addr;
    w_stop_nxt      = 1'b0;
    w_busy_nxt      = r_busy;
    w_overrun_nxt   = r_overrun;
    w_pending_nxt   = r_pending;
    w_next_addr_nxt = r_next_addr;
    w_push          = 1'b0;
    w_code          = MIX_SPACE;
    w_word_done     = 1'b0;

    // An IN issued while busy is queued; the CPU stays blocked until this block ends.
    if (start && r_busy) begin
      w_pending_nxt   = 1'b1;
      w_next_addr_nxt = addressin;
    end else begin
      w_pending_nxt   = r_pending;
    end

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_stop_nxt = 1'b1;
          if (field == 6'(CARD_UNIT) || field == 6'(TERM_UNIT)) begin
            w_is_term_nxt = (field == 6'(TERM_UNIT));
            w_addr_nxt    = addressin;
            w_wc_nxt      = 5'd0;
            w_cc_nxt      = 3'd0;
            w_acc_nxt     = 24'd0;
            w_busy_nxt    = 1'b1;
            w_overrun_nxt = 1'b0;
            w_state_nxt   = S_RECV;
          end else begin
            w_busy_nxt    = 1'b0;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RECV: begin
        if (w_byte_valid) begin
          if (w_byte == ASCII_LF) begin
            w_state_nxt = S_RECV;
          end else if (w_byte == ASCII_CR) begin
            if (r_cc != 3'd0 || r_wc < w_nwords) w_state_nxt = S_PAD;
            else                                 w_state_nxt = S_FLUSH;
          end else begin
            w_push = 1'b1;
            w_code = w_mapped;
            if (w_last_char) w_state_nxt = S_SKIP;
            else             w_state_nxt = S_RECV;
          end
        end else begin
          w_state_nxt = S_RECV;
        end
      end
      S_PAD: begin
        w_push = 1'b1;
        w_code = MIX_SPACE;
        if (w_last_char) w_state_nxt = S_FLUSH;
        else             w_state_nxt = S_PAD;
      end
      S_SKIP: begin
        if (w_byte_valid && w_byte == ASCII_CR) w_state_nxt = S_FLUSH;
        else                                    w_state_nxt = S_SKIP;
      end
      S_FLUSH: begin
        if (!r_store) begin
          if (w_pending_nxt) begin
            w_addr_nxt    = w_next_addr_nxt;
            w_wc_nxt      = 5'd0;
            w_cc_nxt      = 3'd0;
            w_pending_nxt = 1'b0;
            w_stop_nxt    = 1'b1;
            w_state_nxt   = S_RECV;
          end else begin
            w_busy_nxt    = 1'b0;
            w_state_nxt   = S_IDLE;
          end
        end else begin
          w_state_nxt = S_FLUSH;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Character packing; a completed word is dropped if the previous one is still unaccepted.
    if (w_push) begin
      if (r_cc == 3'd4) begin
        w_word_done = 1'b1;
        w_cc_nxt    = 3'd0;
        w_wc_nxt    = r_wc + 5'd1;
        if (!r_store || ack) begin
          w_out_nxt   = {r_acc, w_code};
          w_store_nxt = 1'b1;
        end else begin
          w_overrun_nxt = 1'b1;
        end
      end else begin
        w_acc_nxt = {r_acc[17:0], w_code};
        w_cc_nxt  = r_cc + 3'd1;
      end
    end else begin
      w_word_done = 1'b0;
    end

    if (r_store && ack) begin
      w_addr_nxt  = r_addr + 12'd1;
      w_store_nxt = w_word_done;
    end else begin
      w_addr_nxt  = w_addr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_is_term   <= 1'b0;
      r_wc        <= 5'd0;
      r_cc        <= 3'd0;
      r_acc       <= 24'd0;
      r_out       <= 30'd0;
      r_store     <= 1'b0;
      r_addr      <= 12'd0;
      r_stop      <= 1'b0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
      r_pending   <= 1'b0;
      r_next_addr <= 12'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_is_term   <= w_is_term_nxt;
      r_wc        <= w_wc_nxt;
      r_cc        <= w_cc_nxt;
      r_acc       <= w_acc_nxt;
      r_out       <= w_out_nxt;
      r_store     <= w_store_nxt;
      r_addr      <= w_addr_nxt;
      r_stop      <= w_stop_nxt;
      r_busy      <= w_busy_nxt;
      r_overrun   <= w_overrun_nxt;
      r_pending   <= w_pending_nxt;
      r_next_addr <= w_next_addr_nxt;
    end
  end

  assign addressout = r_addr;
  assign out        = r_out;
  assign store      = r_store;
  assign stop       = r_stop;
  assign busy       = r_busy;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_mix_in_unit.sv
// Directed bench for mix_in_unit: a vector table of short lines plus hand-written block sequences.
`timescale 1ns/1ps
module tb_mix_in_unit;

  localparam int CPB  = 8;
  localparam int CARD = 16;
  localparam int TERM = 19;

  logic        clk = 1'b0;
  logic        reset, rx, start, ack, ack_en;
  logic [5:0]  field;
  logic [11:0] addressin, addressout;
  logic [29:0] out;
  logic        store, stop, busy, overrun;

  int n_vec = 0;
  int n_err = 0;
  int n_stores = 0;
  int n_stops = 0;
  logic [29:0] mem [0:4095];

  mix_in_unit #(.CLKS_PER_BIT(CPB), .CARD_UNIT(CARD), .TERM_UNIT(TERM),
                .CARD_WORDS(16), .TERM_WORDS(14)) dut (
    .clk(clk), .reset(reset), .rx(rx), .start(start), .field(field),
    .addressin(addressin), .addressout(addressout), .out(out), .store(store),
    .ack(ack), .stop(stop), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Memory model: acknowledges every pending store and records it; counts stop pulses.
  initial begin
    ack = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = 30'h3FFF_FFFF;
    forever begin
      @(negedge clk);
      ack = ack_en && store;
      if (ack) begin
        mem[addressout] = out;
        n_stores++;
      end
      if (stop) n_stops++;
    end
  end

  typedef struct {
    logic [39:0] chars;
    int          n;
    logic [29:0] exp;
  } vec_t;
  vec_t vt[8];

  function automatic logic [29:0] pack5(input int a, input int b, input int c, input int d, input int e);
    return {a[5:0], b[5:0], c[5:0], d[5:0], e[5:0]};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = 1'b1;
    tick(CPB);
  endtask

  task automatic do_start(input logic [5:0] f, input logic [11:0] a);
    start = 1'b1;
    field = f;
    addressin = a;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 3000 && busy; i++) tick(1);
    check(nm, {31'd0, busy}, 32'd0);
    tick(2);
  endtask

  int s0, p0, zeros;
  logic [11:0] a;

  initial begin
    vt[0] = '{"ABCDE", 5, pack5(1, 2, 3, 4, 5)};
    vt[1] = '{"IJRSZ", 5, pack5(9, 11, 19, 22, 29)};
    vt[2] = '{"09 .,", 5, pack5(30, 39, 0, 40, 41)};
    vt[3] = '{"()+-*", 5, pack5(42, 43, 44, 45, 46)};
    vt[4] = '{"/=$<>", 5, pack5(47, 48, 49, 50, 51)};
    vt[5] = '{"@;:'#", 5, pack5(52, 53, 54, 55, 0)};
`ifdef MIX_IN_LOWERCASE_EN
    vt[6] = '{"abcz", 4, pack5(1, 2, 3, 29, 0)};
`else
    vt[6] = '{"abcz", 4, pack5(0, 0, 0, 0, 0)};
`endif
    vt[7] = '{"Q\nRS", 4, pack5(18, 19, 22, 0, 0)};

    reset = 1'b1; rx = 1'b1; start = 1'b0; field = 6'd0; addressin = 12'd0; ack_en = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
    check("reset_outputs", {16'd0, busy, store, stop, overrun, addressout}, 32'd0);
    check("reset_out", {2'd0, out}, 32'd0);

    // Table: one TERM block per vector, first word compared.
    for (int k = 0; k < 8; k++) begin
      a = 12'(1000 + 20 * k);
      do_start(6'(TERM), a);
      for (int i = 0; i < vt[k].n; i++) send_byte(vt[k].chars[8 * (vt[k].n - 1 - i) +: 8]);
      send_byte(8'd13);
      wait_idle("vec_idle");
      check($sformatf("vec%0d_word", k), {2'd0, mem[a]}, {2'd0, vt[k].exp});
    end

    // TERM "AB" CR at 100: one data word, 13 space words, single stop pulse.
    s0 = n_stores; p0 = n_stops;
    do_start(6'(TERM), 12'd100);
    check("term_busy", {31'd0, busy}, 32'd1);
    send_byte("A"); send_byte("B"); send_byte(8'd13);
    wait_idle("term_idle");
    check("term_word0", {2'd0, mem[100]}, {2'd0, pack5(1, 2, 0, 0, 0)});
    zeros = 0;
    for (int j = 101; j <= 113; j++) if (mem[j] == 30'd0) zeros++;
    check("term_pad_words", zeros, 13);
    check("term_stores", n_stores - s0, 14);
    check("term_stops", n_stops - p0, 1);

    // Unknown unit: stop pulse, never busy, nothing stored.
    s0 = n_stores; p0 = n_stops;
    do_start(6'd5, 12'd50);
    check("bad_unit_busy", {31'd0, busy}, 32'd0);
    tick(20);
    check("bad_unit_stop", n_stops - p0, 1);
    check("bad_unit_stores", n_stores - s0, 0);

    // CARD: 80 digits fill all 16 words, CR then ends the block.
    s0 = n_stores;
    do_start(6'(CARD), 12'd0);
    for (int i = 0; i < 80; i++) send_byte(8'(48 + (i % 10)));
    check("card_busy_before_cr", {31'd0, busy}, 32'd1);
    send_byte(8'd13);
    wait_idle("card_idle");
    check("card_stores", n_stores - s0, 16);
    check("card_word0", {2'd0, mem[0]}, {2'd0, pack5(30, 31, 32, 33, 34)});
    check("card_word15", {2'd0, mem[15]}, {2'd0, pack5(35, 36, 37, 38, 39)});

    // TERM with 75 chars: the last five are skipped, block ends only on CR.
    s0 = n_stores;
    do_start(6'(TERM), 12'd500);
    for (int i = 0; i < 75; i++) send_byte(8'(65 + (i % 10)));
    tick(4);
    check("skip_busy", {31'd0, busy}, 32'd1);
    check("skip_stores_before_cr", n_stores - s0, 14);
    send_byte(8'd13);
    wait_idle("skip_idle");
    check("skip_stores", n_stores - s0, 14);
    check("skip_word13", {2'd0, mem[513]}, {2'd0, pack5(6, 7, 8, 9, 11)});

    // Second IN while busy: held until block 1 completes, then resumes at 200.
    do_start(6'(TERM), 12'd300);
    tick(2);
    p0 = n_stops;
    send_byte("A");
    do_start(6'(TERM), 12'd200);
    tick(2);
    check("pend_no_stop", n_stops - p0, 0);
    send_byte(8'd13);
    for (int i = 0; i < 1000 && !stop; i++) tick(1);
    check("pend_stop_seen", {31'd0, stop}, 32'd1);
    tick(1);
    check("pend_busy", {31'd0, busy}, 32'd1);
    check("pend_addr", {20'd0, addressout}, 32'd200);
    send_byte("B"); send_byte(8'd13);
    wait_idle("pend_idle");
    check("pend_block1", {2'd0, mem[300]}, {2'd0, pack5(1, 0, 0, 0, 0)});
    check("pend_block2", {2'd0, mem[200]}, {2'd0, pack5(2, 0, 0, 0, 0)});
    check("pend_stops", n_stops - p0, 1);

    // Overrun: ack withheld across two word completions.
    s0 = n_stores;
    ack_en = 1'b0;
    do_start(6'(TERM), 12'd400);
    for (int i = 0; i < 10; i++) send_byte(8'(65 + i));
    tick(2);
    check("ovr_flag", {31'd0, overrun}, 32'd1);
    check("ovr_store_held", {31'd0, store}, 32'd1);
    check("ovr_out_held", {2'd0, out}, {2'd0, pack5(1, 2, 3, 4, 5)});
    check("ovr_addr_held", {20'd0, addressout}, 32'd400);
    ack_en = 1'b1;
    send_byte(8'd13);
    wait_idle("ovr_idle");
    check("ovr_first_word", {2'd0, mem[400]}, {2'd0, pack5(1, 2, 3, 4, 5)});
    check("ovr_dropped", {2'd0, mem[401]}, 32'd0);
    check("ovr_stores", n_stores - s0, 13);
    check("ovr_sticky", {31'd0, overrun}, 32'd1);

    // Accepted start clears overrun; reset mid-block aborts with a word pending.
    do_start(6'(TERM), 12'd600);
    check("ovr_cleared", {31'd0, overrun}, 32'd0);
    ack_en = 1'b0;
    for (int i = 0; i < 5; i++) send_byte(8'(65 + i));
    tick(2);
    check("rst_pre_store", {31'd0, store}, 32'd1);
    s0 = n_stores;
    reset = 1'b1;
    tick(1);
    check("rst_mid_block", {30'd0, busy, store}, 32'd0);
    reset = 1'b0;
    ack_en = 1'b1;
    tick(20);
    check("rst_no_store", n_stores - s0, 0);
    check("rst_idle", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
